// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the MMIO bus controller.
// Provides FSM state enum, slot indices, default decode table, counter width.
package mio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam int SLOT_RAM  = 0;
    localparam int SLOT_SEG7 = 1;
    localparam int SLOT_LED  = 2;
    localparam int SLOT_CNT  = 3;

    localparam int ERR_CNT_W = 8;

    // Index 0 is the rightmost element.
    localparam logic [3:0][31:0] SLOT_BASE = {
        32'hF000_0004,
        32'hF000_0000,
        32'hE000_0000,
        32'h0000_0000
    };

    localparam logic [3:0][31:0] SLOT_MASK = {
        32'hF000_0004,
        32'hF000_0004,
        32'hF000_0000,
        32'hF000_0000
    };

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational first-match address decoder over a base/mask table.
// Ports: addr, base/mask tables in; hit flag and lowest hitting slot index out.
module mio_addr_decode #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [31:0]        addr,
    input  logic [N-1:0][31:0] base,
    input  logic [N-1:0][31:0] mask,
    output logic               hit,
    output logic [IW-1:0]      idx
);

    // Scanning from the top down lets the lowest match overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr & mask[i]) == base[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered MMIO bus controller: CPU data port to N one-hot selected slots.
// Ports: clk/rst, cpu_* request/response, slv_* select/strobe/data, err_cnt.
module mio_bus_ctrl
    import mio_bus_pkg::*;
#(
    parameter int N_SLV   = 4,
    parameter int SLV_AW  = 10,
    parameter int TIMEOUT = 16,
    parameter logic [N_SLV-1:0][31:0] SLV_BASE = SLOT_BASE,
    parameter logic [N_SLV-1:0][31:0] SLV_MASK = SLOT_MASK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_rdy,
    output logic                   cpu_err,
    output logic [N_SLV-1:0]       slv_sel,
    output logic                   slv_we,
    output logic [SLV_AW-1:0]      slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [N_SLV*32-1:0]    slv_rdata,
    input  logic [N_SLV-1:0]       slv_ack,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [IW-1:0]          slot_q, slot_d;
    logic [N_SLV-1:0]       sel_q, sel_d;
    logic                   we_q, we_d;
    logic [SLV_AW-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rdy_q, rdy_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic                   ack_hit;
    logic [31:0]            rd_sel;

    mio_addr_decode #(
        .N  (N_SLV),
        .IW (IW)
    ) u_dec (
        .addr (cpu_addr),
        .base (SLV_BASE),
        .mask (SLV_MASK),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign ack_hit = slv_ack[slot_q];
    assign rd_sel  = slv_rdata[32*int'(slot_q) +: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            slot_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        slot_d  = slot_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[SLV_AW+1:2];
                    wdata_d = cpu_wdata;
                    slot_d  = dec_idx;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                        timer_d = '0;
                        sel_d   = N_SLV'(1) << dec_idx;
                        we_d    = cpu_we;
                    end else begin
                        state_d = ST_DONE;
                        rdy_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end

            ST_ACCESS: begin
                timer_d = timer_q + TW'(1);
                // Ack is checked first so it wins a same-cycle timeout.
                if (ack_hit) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = rd_sel;
                    end
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (err_q && cnt_q != '1) begin
                    cnt_d = cnt_q + ERR_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign cpu_rdy   = rdy_q;
    assign cpu_err   = err_q;
    assign slv_sel   = sel_q;
    assign slv_we    = we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: per-cycle expectation schedule
// built from the latency rules, plus literal spot checks.
module tb_mio_bus_ctrl;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int TO   = 16;
    localparam int MAXC = 2048;

    logic            clk;
    logic            rst;
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [31:0]     cpu_wdata;
    logic [31:0]     cpu_rdata;
    logic            cpu_rdy;
    logic            cpu_err;
    logic [N-1:0]    slv_sel;
    logic            slv_we;
    logic [AW-1:0]   slv_addr;
    logic [31:0]     slv_wdata;
    logic [N*32-1:0] slv_rdata;
    logic [N-1:0]    slv_ack;
    logic [7:0]      err_cnt;

    mio_bus_ctrl #(
        .N_SLV   (N),
        .SLV_AW  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ack   (slv_ack),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit running = 1'b1;

    // Expected-output schedule indexed by absolute cycle.
    logic [N-1:0] e_sel   [MAXC];
    logic         e_we    [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [31:0]  e_wdata [MAXC];
    logic         e_rdy   [MAXC];
    logic         e_err   [MAXC];
    logic         e_rupd  [MAXC];
    logic [31:0]  e_rval  [MAXC];
    logic         e_cinc  [MAXC];
    logic         e_rst   [MAXC];

    logic [31:0] m_rdata;
    int          m_cnt;

    logic [31:0] tbase [N];
    logic [31:0] tmask [N];

    initial begin
        tbase[0] = 32'h0000_0000; tmask[0] = 32'hF000_0000;
        tbase[1] = 32'hE000_0000; tmask[1] = 32'hF000_0000;
        tbase[2] = 32'hF000_0000; tmask[2] = 32'hF000_0004;
        tbase[3] = 32'hF000_0004; tmask[3] = 32'hF000_0004;
        for (int i = 0; i < MAXC; i++) begin
            e_sel[i] = '0;  e_we[i] = 1'b0; e_addr[i] = '0;
            e_wdata[i] = '0; e_rdy[i] = 1'b0; e_err[i] = 1'b0;
            e_rupd[i] = 1'b0; e_rval[i] = '0; e_cinc[i] = 1'b0;
            e_rst[i] = 1'b0;
        end
        e_rst[1] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Lowest matching table entry wins; -1 means unmapped.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & tmask[i]) == tbase[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (running && cyc >= 1 && cyc < MAXC) begin
            if (e_rst[cyc]) begin
                m_rdata = '0;
                m_cnt   = 0;
            end
            if (e_rupd[cyc]) m_rdata = e_rval[cyc];
            if (e_cinc[cyc] && m_cnt < 255) m_cnt++;
            chk("sel", 32'(slv_sel), 32'(e_sel[cyc]));
            chk("rdy", 32'(cpu_rdy), 32'(e_rdy[cyc]));
            chk("rdata", cpu_rdata, m_rdata);
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (e_rdy[cyc])
                chk("err", 32'(cpu_err), 32'(e_err[cyc]));
            if (e_sel[cyc] != '0) begin
                chk("slv_we", 32'(slv_we), 32'(e_we[cyc]));
                chk("slv_addr", 32'(slv_addr), 32'(e_addr[cyc]));
                chk("slv_wdata", slv_wdata, e_wdata[cyc]);
            end
            if (e_rst[cyc]) begin
                chk("rst_err", 32'(cpu_err), 32'd0);
                chk("rst_we", 32'(slv_we), 32'd0);
                chk("rst_addr", 32'(slv_addr), 32'd0);
                chk("rst_wdata", slv_wdata, 32'd0);
            end
        end
    end

    // One transaction starting in the next IDLE cycle. ack_k is the
    // access cycle the decoded slot acks in (0 = never); spur acks other
    // lines throughout. Returns at the negedge of the completion cycle.
    task automatic access(input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input int ack_k,
                          input logic [31:0] rv, input logic [N-1:0] spur,
                          output int sel_n, output logic rdy_o,
                          output logic err_o, output logic [31:0] rd_o);
        int t0, s, fin;
        bit acked;
        @(posedge clk); #1;
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        slv_ack = '0;
        s = decode(a);
        for (int i = 0; i < N; i++)
            slv_rdata[32*i +: 32] = (i == s) ? rv : (32'hDEAD_0000 | i);
        if (s < 0) begin
            fin = 0;
            acked = 1'b0;
        end else if (ack_k >= 1 && ack_k <= TO) begin
            fin = ack_k;
            acked = 1'b1;
        end else begin
            fin = TO;
            acked = 1'b0;
        end
        for (int c = 1; c <= fin; c++) begin
            e_sel[t0+c]   = 4'b0001 << s;
            e_we[t0+c]    = we;
            e_addr[t0+c]  = a[AW+1:2];
            e_wdata[t0+c] = wd;
        end
        e_rdy[t0+fin+1] = 1'b1;
        e_err[t0+fin+1] = !acked;
        if (!acked) begin
            e_rupd[t0+fin+1] = 1'b1;
            e_rval[t0+fin+1] = '0;
            e_cinc[t0+fin+2] = 1'b1;
        end else if (!we) begin
            e_rupd[t0+fin+1] = 1'b1;
            e_rval[t0+fin+1] = rv;
        end
        sel_n = 0;
        for (int c = 1; c <= fin + 1; c++) begin
            @(posedge clk); #1;
            slv_ack = spur;
            if (c == ack_k && s >= 0) slv_ack[s] = 1'b1;
            @(negedge clk);
            if (slv_sel != '0) sel_n++;
        end
        rdy_o = cpu_rdy;
        err_o = cpu_err;
        rd_o  = cpu_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            slv_ack = '0;
        end
    endtask

    int          sn;
    logic        ry, er;
    logic [31:0] rd;
    int          t0;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; slv_rdata = '0; slv_ack = '0;
        m_rdata = '0; m_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_sel", 32'(slv_sel), 32'd0);
        chk("lit_reset_cnt", 32'(err_cnt), 32'd0);

        // RAM read, combinational ack in cycle 1.
        access(32'h0000_0010, 1'b0, 32'h0, 1, 32'h1234_5678, '0,
               sn, ry, er, rd);
        chk("lit_rd_selcyc", 32'(sn), 32'd1);
        chk("lit_rd_rdy", 32'(ry), 32'd1);
        chk("lit_rd_err", 32'(er), 32'd0);
        chk("lit_rd_data", rd, 32'h1234_5678);

        // Counter write, ack in cycle 3.
        access(32'hF000_0004, 1'b1, 32'h0000_00A5, 3, 32'h9999_9999, '0,
               sn, ry, er, rd);
        chk("lit_wr_selcyc", 32'(sn), 32'd3);
        chk("lit_wr_rdy", 32'(ry), 32'd1);
        chk("lit_wr_data_kept", rd, 32'h1234_5678);
        idle(1);

        // Unmapped read.
        access(32'h4000_0000, 1'b0, 32'h0, 1, 32'h0, '0,
               sn, ry, er, rd);
        chk("lit_um_selcyc", 32'(sn), 32'd0);
        chk("lit_um_err", 32'(er), 32'd1);
        chk("lit_um_data", rd, 32'd0);
        idle(1);
        @(negedge clk);
        chk("lit_um_cnt", 32'(err_cnt), 32'd1);

        // seg7 never acks; stray ack on slot 0 during the wait.
        access(32'hE000_0000, 1'b0, 32'h0, 0, 32'h7777_0000, 4'b0001,
               sn, ry, er, rd);
        chk("lit_to_selcyc", 32'(sn), 32'd16);
        chk("lit_to_err", 32'(er), 32'd1);
        idle(1);
        @(negedge clk);
        chk("lit_to_cnt", 32'(err_cnt), 32'd2);

        // Reset during cycle 2 of a seg7 access.
        @(posedge clk); #1;
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = 32'hE000_0000; cpu_wdata = 32'h55;
        for (int c = 1; c <= 2; c++) begin
            e_sel[t0+c] = 4'b0010;
            e_we[t0+c] = 1'b0;
            e_addr[t0+c] = '0;
            e_wdata[t0+c] = 32'h55;
        end
        e_rst[t0+3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0; slv_ack = 4'b0010;
        @(negedge clk);
        chk("lit_rst_sel", 32'(slv_sel), 32'd0);
        chk("lit_rst_rdy", 32'(cpu_rdy), 32'd0);
        chk("lit_rst_cnt", 32'(err_cnt), 32'd0);
        idle(2);

        // Next request decodes normally: LED read with stray slot-3 ack.
        access(32'hF000_0000, 1'b0, 32'h0, 2, 32'h0000_CAFE, 4'b1000,
               sn, ry, er, rd);
        chk("lit_led_data", rd, 32'h0000_CAFE);
        chk("lit_led_err", 32'(er), 32'd0);
        idle(1);

        // Ack lands on the timeout cycle.
        access(32'hE000_0008, 1'b0, 32'h0, TO, 32'hABCD_0001, '0,
               sn, ry, er, rd);
        chk("lit_tie_err", 32'(er), 32'd0);
        chk("lit_tie_data", rd, 32'hABCD_0001);

        // Back-to-back unmapped with req held high.
        for (int i = 0; i < 300; i++)
            access(32'h4000_0000 + 32'(i * 4), 1'b0, 32'h0, 0, 32'h0, '0,
                   sn, ry, er, rd);
        idle(1);
        @(negedge clk);
        chk("lit_sat_cnt", 32'(err_cnt), 32'd255);
        idle(3);

        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Parametrised, registered memory-mapped I/O bus controller between the CPU data port and N peripheral slots (data RAM, seg7 GPIO, LED GPIO, counter, and future devices). It decodes each CPU access against a per-slot base/mask table and drives one-hot slot selects. It waits for a per-slot acknowledge with a bounded timeout and returns read data with a ready/error handshake. Unmapped or timed-out accesses complete with an error, and a saturating error counter records them.

## Interface
Parameters:
- `N_SLV`, 4: number of peripheral slots.
- `SLV_AW`, 10: slave word-address width.
- `TIMEOUT`, 16: cycles to wait for ack; 0 means wait forever.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: access request; held until `cpu_rdy`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: registered read data.
- `cpu_rdy` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_rdy`; unmapped or timeout.
- `slv_sel` out N_SLV: one-hot slot select.
- `slv_we` out 1: write strobe, qualified by `slv_sel`.
- `slv_addr` out SLV_AW: `cpu_addr[SLV_AW+1:2]`, latched.
- `slv_wdata` out 32: latched write data.
- `slv_rdata` in N_SLV*32: flattened; slot i at `[32*i+31:32*i]`.
- `slv_ack` in N_SLV: per-slot acknowledge.
- `err_cnt` out 8: saturating error count.

## Operation
- Decode: slot i hits when `(cpu_addr & SLOT_MASK[i]) == SLOT_BASE[i]`. Lowest hit index wins.
- Default table:
  - slot 0 RAM: base 0000_0000, mask F000_0000.
  - slot 1 seg7: base E000_0000, mask F000_0000.
  - slot 2 LED/SW: base F000_0000, mask F000_0004.
  - slot 3 counter: base F000_0004, mask F000_0004.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on `cpu_req`, latch addr, wdata, we and slot index.
    - Hit → ACCESS.
    - Miss → DONE with err=1.
  - ACCESS: `slv_sel[slot]`=1, `slv_we`=latched we; timer increments each cycle.
    - `slv_ack[slot]`=1 → DONE, err=0. On a read, capture `slv_rdata[slot]` into `cpu_rdata`.
    - Else, when TIMEOUT≠0 and timer==TIMEOUT-1 → DONE, err=1.
  - DONE: `cpu_rdy`=1, `cpu_err`=err. If err, increment `err_cnt` (saturates at 255) → IDLE.
- `cpu_rdata` handling:
  - Error completion clears it to 0.
  - Write completion leaves it unchanged.
  - Otherwise holds until the next capture.
- Ignored acks: acks from non-selected slots, and any ack in IDLE or DONE.
- Ack wins over timeout in the same cycle.
- `cpu_req` still high in the IDLE cycle after DONE starts a new transaction with current inputs.
- `slv_addr`, `slv_wdata` and `slv_we` are held stable throughout ACCESS.

## Timing
- Reset values:
  - state IDLE, timer 0.
  - `cpu_rdata`=0, `cpu_rdy`=0, `cpu_err`=0, `err_cnt`=0.
  - `slv_sel`=0, `slv_we`=0, `slv_addr`=0, `slv_wdata`=0.
- `rst` mid-ACCESS: outputs return to reset values at the next edge and no `cpu_rdy` is issued. `err_cnt` is also cleared.
- Latency, with cycle 0 = req sampled in IDLE:
  - `slv_sel` asserted in cycle 1.
  - Ack in cycle k≥1 → `cpu_rdy` in cycle k+1. Minimum 2 cycles; RAM acks combinationally in cycle 1.
  - Unmapped: `cpu_rdy`+`cpu_err` in cycle 1; `slv_sel` never asserted.
  - Timeout: `slv_sel` high for exactly TIMEOUT cycles (1..TIMEOUT), `cpu_rdy` in cycle TIMEOUT+1.
- All outputs are registered; no combinational path from `cpu_*` to `slv_*`.

## Structure
- Package `mio_bus_pkg`:
  - state enum.
  - slot index constants (SLOT_RAM=0, SLOT_SEG7=1, SLOT_LED=2, SLOT_CNT=3).
  - `SLOT_BASE`/`SLOT_MASK` arrays.
  - `ERR_CNT_W`=8.
- Sub-module `mio_addr_decode`: combinational first-match decoder. Inputs: address and tables. Outputs: hit, slot index.
- The timer is `$clog2(TIMEOUT+1)` bits wide (minimum 1) and resets to 0 on entry to ACCESS.

## Test plan
- Read 0x0000_0010, slot 0 acks in cycle 1 with 0x1234_5678:
  - `slv_sel`=0001, `slv_addr`=4, `slv_we`=0.
  - `cpu_rdy`=1 in cycle 2, `cpu_rdata`=0x1234_5678, `cpu_err`=0.
- Write 0xF000_0004 data 0x0000_00A5, slot 3 acks in cycle 3:
  - `slv_sel`=1000, `slv_we`=1, `slv_wdata`=0xA5, all stable cycles 1–3.
  - `cpu_rdy` in cycle 4; `cpu_rdata` unchanged.
- Read 0x4000_0000 (unmapped):
  - `cpu_rdy`=`cpu_err`=1 in cycle 1, `slv_sel` stays 0.
  - `err_cnt`=1, `cpu_rdata`=0.
- Read 0xE000_0000 with slot 1 never acking, TIMEOUT=16:
  - `slv_sel`=0010 for 16 cycles.
  - `cpu_rdy`+`cpu_err` in cycle 17, `err_cnt` increments.
  - Ack on slot 0 during the wait is ignored.
- `rst` in cycle 2 of a slot 1 access:
  - All outputs 0 after the edge, no `cpu_rdy`.
  - A late slot 1 ack is ignored; the next request decodes normally.
- `cpu_req` held high with 300 back-to-back unmapped accesses:
  - A new transaction starts each IDLE cycle.
  - `err_cnt` saturates at 255.
  - Ack and timeout in the same cycle → err=0.
